// File: rtl/icache_dm_if.sv
// Line-fill bus between the instruction cache and the backing instruction memory.
// master = cache side (issues fill requests), slave = memory side (accepts and streams words).
interface icache_dm_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache: same-cycle hits, stall and whole-line fill on miss,
// with flush/kill handling and saturating hit/miss statistics.
module icache_dm #(
  parameter int unsigned Lines     = 16,
  parameter int unsigned WordsLine = 4,
  parameter int unsigned CntW      = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            cpu_req_i,
  input  logic [31:0]     cpu_addr_i,
  output logic [31:0]     cpu_data_o,
  output logic            cpu_stall_o,
  input  logic            flush_i,
  icache_dm_if.master     mem,
  output logic [CntW-1:0] hit_count_o,
  output logic [CntW-1:0] miss_count_o
);

  localparam int unsigned WordW = $clog2(WordsLine);
  localparam int unsigned IdxW  = $clog2(Lines);
  localparam int unsigned LineW = 30 - WordW;
  localparam int unsigned TagW  = LineW - IdxW;

  typedef enum logic [1:0] {StIdle, StReq, StFill} state_e;

  state_e             state_q, state_d;
  logic [LineW-1:0]   line_q, line_d;
  logic [WordW-1:0]   cnt_q, cnt_d;
  logic               kill_q, kill_d;
  logic [Lines-1:0]   valid_q, valid_d;
  logic [CntW-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CntW-1:0]    miss_cnt_q, miss_cnt_d;

  logic [31:0]        data_q [Lines][WordsLine];
  logic [TagW-1:0]    tag_q  [Lines];

  logic [WordW-1:0]   cpu_word;
  logic [IdxW-1:0]    cpu_idx;
  logic [TagW-1:0]    cpu_tag;
  logic [IdxW-1:0]    fill_idx;
  logic [TagW-1:0]    fill_tag;
  logic               hit;
  logic               fill_we;
  logic               last_beat;
  logic               unused_addr;

  assign cpu_word    = cpu_addr_i[2 +: WordW];
  assign cpu_idx     = cpu_addr_i[2 + WordW +: IdxW];
  assign cpu_tag     = cpu_addr_i[31 -: TagW];
  assign fill_idx    = line_q[IdxW-1:0];
  assign fill_tag    = line_q[LineW-1 -: TagW];
  assign unused_addr = ^cpu_addr_i[1:0];

  // Only IDLE serves fetches; during a fill the array may hold a half-written line.
  assign hit = cpu_req_i && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag) &&
               (state_q == StIdle);

  assign cpu_data_o        = hit ? data_q[cpu_idx][cpu_word] : '0;
  assign mem.mem_req_addr  = {line_q, {(WordW + 2){1'b0}}};
  assign hit_count_o       = hit_cnt_q;
  assign miss_count_o      = miss_cnt_q;

  always_comb begin
    state_d           = state_q;
    line_d            = line_q;
    cnt_d             = cnt_q;
    kill_d            = kill_q;
    valid_d           = valid_q;
    hit_cnt_d         = hit_cnt_q;
    miss_cnt_d        = miss_cnt_q;
    fill_we           = 1'b0;
    last_beat         = 1'b0;
    cpu_stall_o       = 1'b0;
    mem.mem_req_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (cpu_req_i && !hit) begin
          cpu_stall_o = 1'b1;
          line_d      = cpu_addr_i[31:2+WordW];
          miss_cnt_d  = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
          state_d     = StReq;
        end
      end
      StReq: begin
        cpu_stall_o       = 1'b1;
        mem.mem_req_valid = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (mem.mem_req_ready) begin
          cnt_d   = '0;
          state_d = StFill;
        end
      end
      StFill: begin
        cpu_stall_o = 1'b1;
        if (flush_i) kill_d = 1'b1;
        if (mem.mem_resp_valid) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == WordW'(WordsLine - 1)) begin
            last_beat = 1'b1;
            state_d   = StIdle;
            // A flush on the final beat must also leave the line invalid.
            if (!kill_q && !flush_i) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (hit) hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + 1'b1;
    if (flush_i) valid_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      line_q     <= '0;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      valid_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      line_q     <= line_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Storage arrays carry no reset; the valid bits alone guard their contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_we) begin
      data_q[fill_idx][cnt_q] <= mem.mem_resp_data;
      if (last_beat) tag_q[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Randomised bench for icache_dm: a line-level cache model and an autonomous backing-memory
// responder predict every fetch result, stall length and statistic.
module tb_icache_dm;
  localparam int unsigned Lines     = 16;
  localparam int unsigned WordsLine = 4;
  localparam int unsigned CntW      = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cpu_req;
  logic [31:0]     cpu_addr;
  logic [31:0]     cpu_data;
  logic            cpu_stall;
  logic            flush;
  logic [CntW-1:0] hit_count;
  logic [CntW-1:0] miss_count;

  icache_dm_if bus ();

  icache_dm #(
    .Lines     (Lines),
    .WordsLine (WordsLine),
    .CntW      (CntW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_req_i    (cpu_req),
    .cpu_addr_i   (cpu_addr),
    .cpu_data_o   (cpu_data),
    .cpu_stall_o  (cpu_stall),
    .flush_i      (flush),
    .mem          (bus),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: which line address each index holds, plus expected statistics.
  bit          m_valid [Lines];
  logic [27:0] m_line  [Lines];
  int          m_hits;
  int          m_misses;
  int          rdy_dly;
  int          beat_gap;
  logic [31:0] exp_fill;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hAAAA, a[17:2]};
  endfunction

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 1'b0;
  endtask

  // Backing memory: waits rdy_dly cycles before accepting, then beat_gap idle cycles before
  // each word; toggles junk responses while no fill is in progress.
  initial begin
    logic [31:0] fa;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(negedge clk);
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (bus.mem_req_valid === 1'b1 && !rst) begin
        fa = bus.mem_req_addr;
        check_eq("req_addr", fa, exp_fill);
        repeat (rdy_dly) begin
          @(negedge clk);
          check_eq("req_hold_valid", {31'd0, bus.mem_req_valid}, 32'd1);
          check_eq("req_hold_addr", bus.mem_req_addr, fa);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        for (int w = 0; w < WordsLine; w++) begin
          repeat (beat_gap) @(negedge clk);
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = mem_word(fa + 32'(4 * w));
          @(negedge clk);
          bus.mem_resp_valid = 1'b0;
          bus.mem_resp_data  = $urandom;
        end
      end else begin
        bus.mem_resp_valid = ($urandom_range(0, 3) == 0);
        bus.mem_resp_data  = $urandom;
      end
    end
  end

  // One fetch held until served; flush_at > 0 pulses flush in that cycle of the miss.
  task automatic fetch(input logic [31:0] a, input int flush_at);
    int          idx;
    int          cyc;
    int          exp_end;
    logic [27:0] ln;
    bit          hit;
    bit          killed;
    idx = int'(a[7:4]);
    ln  = a[31:4];
    hit = m_valid[idx] && (m_line[idx] == ln);
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    #1;
    check_eq("hit_count", {16'd0, hit_count}, m_hits);
    check_eq("miss_count", {16'd0, miss_count}, m_misses);
    if (hit) begin
      check_eq("hit_stall", {31'd0, cpu_stall}, 32'd0);
      check_eq("hit_data", cpu_data, mem_word(a));
      m_hits++;
    end else begin
      check_eq("miss_stall", {31'd0, cpu_stall}, 32'd1);
      check_eq("miss_data", cpu_data, 32'd0);
      m_misses++;
      exp_fill = {ln, 4'h0};
      exp_end  = 2 + rdy_dly + WordsLine * (1 + beat_gap);
      killed   = 1'b0;
      cyc      = 0;
      while (cyc < 300) begin
        @(negedge clk);
        cyc++;
        flush = (cyc == flush_at);
        if (flush) begin
          killed = 1'b1;
          model_clear();
        end
        if (killed && cyc == exp_end) cpu_req = 1'b0;
        #1;
        if (!cpu_stall) break;
      end
      flush = 1'b0;
      check_eq("stall_len", cyc, exp_end);
      if (!killed) begin
        check_eq("fill_data", cpu_data, mem_word(a));
        m_valid[idx] = 1'b1;
        m_line[idx]  = ln;
        m_hits++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    flush   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    cpu_req = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a;
    int          r;
    int          fa;
    rst      = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    flush    = 1'b0;
    rdy_dly  = 0;
    beat_gap = 0;
    exp_fill = '0;
    m_hits   = 0;
    m_misses = 0;
    model_clear();
    repeat (2) @(negedge clk);
    do_reset();
    #1;
    check_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check_eq("rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);

    // Cold miss, then sequential hits within the line.
    fetch(32'h0, -1);
    fetch(32'h4, -1);
    fetch(32'h8, -1);
    fetch(32'hC, -1);
    // Conflict on index 0 evicts the first line.
    fetch(32'h100, -1);
    fetch(32'h0, -1);
    // Slow acceptance and gapped beats.
    rdy_dly  = 3;
    beat_gap = 2;
    fetch(32'h204, -1);
    rdy_dly  = 0;
    beat_gap = 0;
    // Flush on the second fill beat kills the line; the re-fetch misses again.
    fetch(32'h300, 3);
    fetch(32'h300, -1);

    // Reset in the middle of a gapped fill.
    fetch(32'h0, -1);
    beat_gap = 2;
    exp_fill = 32'h400;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 32'h400;
    repeat (5) @(negedge clk);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check_eq("mid_rst_stall", {31'd0, cpu_stall}, 32'd0);
    check_eq("mid_rst_hits", {16'd0, hit_count}, 32'd0);
    check_eq("mid_rst_misses", {16'd0, miss_count}, 32'd0);
    model_clear();
    m_hits   = 0;
    m_misses = 0;
    repeat (20) @(negedge clk);
    beat_gap = 0;
    fetch(32'h0, -1);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_flush();
      end else if (r == 1) begin
        @(negedge clk);
        cpu_req = 1'b0;
        #1;
        check_eq("idle_stall", {31'd0, cpu_stall}, 32'd0);
      end else begin
        rdy_dly  = $urandom_range(0, 3);
        beat_gap = $urandom_range(0, 2);
        a        = '0;
        a[31]    = 1'($urandom_range(0, 1));
        a[9:8]   = 2'($urandom_range(0, 3));
        a[7:4]   = 4'($urandom_range(0, 15));
        a[3:2]   = 2'($urandom_range(0, 3));
        a[1:0]   = 2'($urandom_range(0, 3));
        fa       = -1;
        if (r == 2) fa = $urandom_range(1, 1 + rdy_dly + WordsLine * (1 + beat_gap));
        fetch(a, fa);
      end
    end

    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    check_eq("final_hits", {16'd0, hit_count}, m_hits);
    check_eq("final_misses", {16'd0, miss_count}, m_misses);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
